// File: rtl/vga_bar_sequencer.sv
// -----------------------------------------------------------------------------
// vga_bar_sequencer
//
// Per-frame motion controller for the horizontal colour bars. On each enabled
// new-frame tick it walks the bars one per clock, moving each bar's signed
// vertical offset (relative to the active-area midpoint) by the latched step
// size. A bar reverses direction when it reaches a limit. The whole set of
// offsets is then published on a single edge, so the colour stage never sees
// a mix of old and new positions.
//
// Bar k only starts moving once the committed-frame counter has reached
// k*PHASE_SPACING, which staggers the bars in time.
//
// Ports:
//   i_Clk         pixel clock
//   i_Reset       synchronous, active-high reset
//   i_NewFrame    single-cycle pulse at frame start
//   i_Enable      1 = run, 0 = pause (sampled with i_NewFrame)
//   i_StepSize    pixels moved per frame, unsigned 0..15
//   o_BarPos      packed signed 9-bit offsets, bar k at [9k+8:9k]
//   o_Busy        high while a sequence is in progress (UPDATE/COMMIT)
//   o_UpdateDone  one-cycle pulse when the new offsets are visible
//   o_FrameCount  count of committed sequences (wraps at 16 bits)
//   o_Overrun     sticky: a new-frame tick arrived while busy
// -----------------------------------------------------------------------------
module vga_bar_sequencer #(
  parameter int NUM_BARS      = 3,
  parameter int POS_MIN       = -225,
  parameter int POS_MAX       = 225,
  parameter int PHASE_SPACING = 15
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_NewFrame,
  input  logic                  i_Enable,
  input  logic [3:0]            i_StepSize,
  output logic [9*NUM_BARS-1:0] o_BarPos,
  output logic                  o_Busy,
  output logic                  o_UpdateDone,
  output logic [15:0]           o_FrameCount,
  output logic                  o_Overrun
);

  localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  localparam logic signed [10:0] POS_MAX_W = 11'(POS_MAX);
  localparam logic signed [10:0] POS_MIN_W = 11'(POS_MIN);
  localparam logic signed [8:0]  POS_MAX_P = 9'(POS_MAX);
  localparam logic signed [8:0]  POS_MIN_P = 9'(POS_MIN);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_BARS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_COMMIT
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [3:0]             step_q, step_d;
  logic signed [8:0]      pos_q [NUM_BARS];
  logic signed [8:0]      pos_d [NUM_BARS];
  // Direction bit per bar: 1 = +1 (downward), 0 = -1 (upward).
  logic [NUM_BARS-1:0]    dir_q, dir_d;
  logic [NUM_BARS-1:0]    started_q, started_d;
  logic [9*NUM_BARS-1:0]  bar_pos_q, bar_pos_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic [15:0]            frame_count_q, frame_count_d;

  // Selected-bar datapath (one bar processed per UPDATE cycle).
  logic signed [8:0]      cur_pos;
  logic                   cur_dir;
  logic                   cur_started;
  logic [16:0]            start_thresh;
  logic                   bar_go;
  logic signed [10:0]     pos_ext;
  logic signed [10:0]     step_ext;
  logic signed [10:0]     next_pos;
  logic signed [8:0]      upd_pos;
  logic                   upd_dir;

  // ---------------------------------------------------------------------------
  // Bar select and bounce arithmetic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_pos      = '0;
    cur_dir      = 1'b1;
    cur_started  = 1'b0;
    start_thresh = '0;
    for (int k = 0; k < NUM_BARS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_pos      = pos_q[k];
        cur_dir      = dir_q[k];
        cur_started  = started_q[k];
        start_thresh = 17'(k * PHASE_SPACING);
      end
    end

    // 17-bit compare so k*PHASE_SPACING above 65535 cannot alias.
    bar_go = cur_started || ({1'b0, frame_count_q} >= start_thresh);

    pos_ext  = 11'(cur_pos);
    step_ext = {7'b0, step_q};
    next_pos = cur_dir ? (pos_ext + step_ext) : (pos_ext - step_ext);

    // A zero step never moves a bar, so it must not flip direction either,
    // even when the bar already sits on a limit.
    upd_pos = next_pos[8:0];
    upd_dir = cur_dir;
    if (step_q != 4'd0) begin
      if (cur_dir && (next_pos >= POS_MAX_W)) begin
        upd_pos = POS_MAX_P;
        upd_dir = 1'b0;
      end else if (!cur_dir && (next_pos <= POS_MIN_W)) begin
        upd_pos = POS_MIN_P;
        upd_dir = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    step_d        = step_q;
    pos_d         = pos_q;
    dir_d         = dir_q;
    started_d     = started_q;
    bar_pos_d     = bar_pos_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;
    // Ticks that land while a sequence is running are dropped and flagged.
    overrun_d     = overrun_q | (i_NewFrame & busy_q);

    unique case (state_q)
      S_IDLE: begin
        if (i_NewFrame && i_Enable) begin
          state_d = S_UPDATE;
          idx_d   = '0;
          step_d  = i_StepSize;
        end
      end

      S_UPDATE: begin
        if (bar_go) begin
          for (int k = 0; k < NUM_BARS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              pos_d[k]     = upd_pos;
              dir_d[k]     = upd_dir;
              started_d[k] = 1'b1;
            end
          end
        end

        if (idx_q == LAST_IDX) begin
          // Publish on the edge entering COMMIT, including the last bar's
          // update from this cycle, so done and the new offsets appear
          // together during the COMMIT cycle.
          state_d       = S_COMMIT;
          done_d        = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          for (int k = 0; k < NUM_BARS; k++) begin
            bar_pos_d[9*k +: 9] = pos_d[k];
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_COMMIT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      step_q        <= '0;
      for (int k = 0; k < NUM_BARS; k++) begin
        pos_q[k] <= '0;
      end
      dir_q         <= '1;
      started_q     <= '0;
      bar_pos_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      step_q        <= step_d;
      pos_q         <= pos_d;
      dir_q         <= dir_d;
      started_q     <= started_d;
      bar_pos_q     <= bar_pos_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign o_BarPos     = bar_pos_q;
  assign o_Busy       = busy_q;
  assign o_UpdateDone = done_q;
  assign o_FrameCount = frame_count_q;
  assign o_Overrun    = overrun_q;

endmodule

// File: tb/tb_vga_bar_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vga_bar_sequencer
//
// Directed bench for vga_bar_sequencer with NUM_BARS = 3. Inputs are driven
// and outputs sampled on the falling clock edge; expected values below are
// worked out by hand from the bar motion rules.
// -----------------------------------------------------------------------------
module tb_vga_bar_sequencer;

  localparam int NB = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            nf  = 1'b0;
  logic            en  = 1'b0;
  logic [3:0]      step = 4'd0;
  logic [9*NB-1:0] bar_pos;
  logic            busy;
  logic            done;
  logic [15:0]     fc;
  logic            overrun;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_bar_sequencer #(
    .NUM_BARS      (NB),
    .POS_MIN       (-225),
    .POS_MAX       (225),
    .PHASE_SPACING (15)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_NewFrame   (nf),
    .i_Enable     (en),
    .i_StepSize   (step),
    .o_BarPos     (bar_pos),
    .o_Busy       (busy),
    .o_UpdateDone (done),
    .o_FrameCount (fc),
    .o_Overrun    (overrun)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] bar(input int k);
    logic signed [8:0] b;
    b = bar_pos[9*k +: 9];
    return 32'(b);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    nf  = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One enabled frame. Enable and step are scrambled right after the tick
  // to show the sequence keeps the values it latched.
  task automatic run_frame(input logic [3:0] s);
    int n;
    @(negedge clk);
    nf   = 1'b1;
    en   = 1'b1;
    step = s;
    @(negedge clk);
    nf   = 1'b0;
    en   = 1'b0;
    step = ~s;
    n = 0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 1);
    @(negedge clk);
  endtask

  initial begin
    int pulses;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_barpos",  {5'b0, bar_pos}, 0);
    check("rst_busy",    32'(busy), 0);
    check("rst_done",    32'(done), 0);
    check("rst_fc",      32'(fc), 0);
    check("rst_overrun", 32'(overrun), 0);

    // ---------------- first frame, cycle by cycle ----------------
    @(negedge clk);               // cycle 1: tick
    nf = 1'b1; en = 1'b1; step = 4'd2;
    @(negedge clk);               // cycle 2: UPDATE bar 0
    nf = 1'b0; en = 1'b0; step = 4'd9;
    check("f1_c2_busy", 32'(busy), 1);
    check("f1_c2_done", 32'(done), 0);
    @(negedge clk);               // cycle 3
    check("f1_c3_busy", 32'(busy), 1);
    check("f1_c3_done", 32'(done), 0);
    @(negedge clk);               // cycle 4
    check("f1_c4_busy", 32'(busy), 1);
    check("f1_c4_done", 32'(done), 0);
    @(negedge clk);               // cycle 5: COMMIT
    check("f1_c5_busy",   32'(busy), 1);
    check("f1_c5_done",   32'(done), 1);
    check("f1_c5_barpos", {5'b0, bar_pos}, 2);
    check("f1_c5_fc",     32'(fc), 1);
    @(negedge clk);               // cycle 6: back in IDLE
    check("f1_c6_busy", 32'(busy), 0);
    check("f1_c6_done", 32'(done), 0);

    // ---------------- bounce at step 2 ----------------
    for (int i = 2; i <= 112; i++) run_frame(4'd2);
    check("f112_bar0", bar(0), 224);
    check("f112_bar1", bar(1), 194);
    check("f112_bar2", bar(2), 164);
    check("f112_fc",   32'(fc), 112);
    run_frame(4'd2);
    check("f113_bar0_clamp", bar(0), 225);
    run_frame(4'd2);
    check("f114_bar0", bar(0), 223);
    run_frame(4'd2);
    check("f115_bar0", bar(0), 221);
    for (int i = 116; i <= 337; i++) run_frame(4'd2);
    check("f337_bar0", bar(0), -223);
    run_frame(4'd2);
    check("f338_bar0_clamp", bar(0), -225);
    run_frame(4'd2);
    check("f339_bar0", bar(0), -223);
    check("f339_fc", 32'(fc), 339);
    check("f339_overrun", 32'(overrun), 0);

    // ---------------- start stagger at step 1 ----------------
    do_reset();
    for (int i = 1; i <= 15; i++) run_frame(4'd1);
    check("s15_bar0", bar(0), 15);
    check("s15_bar1", bar(1), 0);
    run_frame(4'd1);
    check("s16_bar1", bar(1), 1);
    for (int i = 17; i <= 30; i++) run_frame(4'd1);
    check("s30_bar1", bar(1), 15);
    check("s30_bar2", bar(2), 0);
    run_frame(4'd1);
    check("s31_bar0", bar(0), 31);
    check("s31_bar1", bar(1), 16);
    check("s31_bar2", bar(2), 1);

    // ---------------- overrun ----------------
    @(negedge clk);               // cycle 1: tick
    nf = 1'b1; en = 1'b1; step = 4'd1;
    @(negedge clk);               // cycle 2
    nf = 1'b0;
    @(negedge clk);               // cycle 3: 2nd cycle of sequence
    nf = 1'b1;
    @(negedge clk);               // cycle 4
    nf = 1'b0;
    @(negedge clk);               // cycle 5: COMMIT
    check("ovr_commit_done", 32'(done), 1);
    nf = 1'b1;
    @(negedge clk);               // cycle 6
    nf = 1'b0; en = 1'b0;
    check("ovr_busy",    32'(busy), 0);
    check("ovr_flag",    32'(overrun), 1);
    check("ovr_fc",      32'(fc), 32);
    check("ovr_bar0",    bar(0), 32);
    repeat (3) @(negedge clk);
    check("ovr_fc_hold", 32'(fc), 32);
    check("ovr_sticky",  32'(overrun), 1);

    // ---------------- pause ----------------
    do_reset();
    run_frame(4'd2);
    check("p_pre_bar0", bar(0), 2);
    check("p_pre_fc",   32'(fc), 1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nf = 1'b1; en = 1'b0; step = 4'd5;
      repeat (6) begin
        @(negedge clk);
        nf = 1'b0;
        if (done || busy) pulses++;
      end
    end
    check("p_activity", pulses, 0);
    check("p_fc",       32'(fc), 1);
    check("p_barpos",   {5'b0, bar_pos}, 2);
    check("p_overrun",  32'(overrun), 0);
    run_frame(4'd2);
    check("p_post_bar0", bar(0), 4);
    check("p_post_fc",   32'(fc), 2);

    // ---------------- reset mid-sequence ----------------
    @(negedge clk);               // cycle 1: tick
    nf = 1'b1; en = 1'b1; step = 4'd2;
    @(negedge clk);               // cycle 2: UPDATE bar 0
    nf = 1'b0; en = 1'b0;
    @(negedge clk);               // cycle 3: UPDATE bar 1
    rst = 1'b1;
    @(negedge clk);               // cycle 4
    rst = 1'b0;
    check("r_barpos",  {5'b0, bar_pos}, 0);
    check("r_busy",    32'(busy), 0);
    check("r_done",    32'(done), 0);
    check("r_fc",      32'(fc), 0);
    check("r_overrun", 32'(overrun), 0);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("r_no_done", pulses, 0);
    run_frame(4'd3);
    check("r_next_bar0", bar(0), 3);
    check("r_next_fc",   32'(fc), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
